pipe_skid_stage: RTL
====================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the payload field (ALU result, store data, immediate, PC+4 packed by the instantiator).
REQ-002 The block SHALL have parameter CTRL_W, default 8, giving the width of the control field (regWrite, memWrite, resultSrc, funct3, writeAddress bits); it SHALL be legal from 1 to 32.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents an instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage can accept this cycle.
REQ-007 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control field.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port flush, input, 1 bit: kills every held and incoming instruction.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the downstream stage sees a live instruction.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes this cycle.
REQ-012 The block SHALL have port out_ctrl, output, CTRL_W bits: control field of the head entry.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: payload of the head entry.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of held entries, 0 to 2.

Function
REQ-015 The block SHALL define accept = in_valid & in_ready & !flush and pop = out_valid & out_ready.
REQ-016 The block SHALL implement two entries, main (head, drives the outputs) and skid, tracked by states EMPTY, ONE and TWO.
REQ-017 In EMPTY, the block SHALL go to ONE on accept, loading main; otherwise it SHALL stay in EMPTY.
REQ-018 In ONE, on accept & pop the block SHALL reload main and stay in ONE.
REQ-019 In ONE, on accept & !pop the block SHALL load skid and go to TWO.
REQ-020 In ONE, on !accept & pop the block SHALL go to EMPTY; with neither accept nor pop it SHALL hold.
REQ-021 In TWO, on pop the block SHALL copy skid into main and go to ONE; otherwise it SHALL hold.
REQ-022 The block SHALL drive in_ready = (state != TWO) & !rst, as a registered-state decode with no combinational path from out_ready.
REQ-023 The block SHALL have a latency of 1 cycle: data accepted at edge N SHALL appear on out_data after edge N when the stage was EMPTY or being popped.
REQ-024 out_valid SHALL equal (state != EMPTY).
REQ-025 The block SHALL force out_ctrl to all zeros whenever out_valid = 0, so that a bubble never asserts a write enable.
REQ-026 The block SHALL hold out_data and out_ctrl stable while out_valid & !out_ready.
REQ-027 A flush SHALL force the state to EMPTY at the next edge, discarding main, skid and any simultaneous input; flush SHALL take priority over accept and pop.
REQ-028 occupancy SHALL read 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-029 The block SHALL preserve ordering: entries SHALL leave in acceptance order, with no loss or duplication absent flush.

Reset
REQ-030 With rst high at an edge, the block SHALL set state = EMPTY and clear main and skid to zero.
REQ-031 After reset, out_valid SHALL be 0, out_ctrl 0, out_data 0 and occupancy 0.
REQ-032 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.
REQ-033 A reset asserted mid-operation SHALL discard all held entries in the same manner as flush.

Structure
REQ-034 A shared package pipe_pkg SHALL hold the state enum (EMPTY/ONE/TWO) and the default DATA_W and CTRL_W constants.
REQ-035 The block SHALL instantiate sub-module pipe_slot twice (main, skid): a CTRL_W+DATA_W register with load enable and synchronous clear.

Verification
REQ-036 The bench SHALL check reset: rst high for 2 cycles -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0, then in_ready=1 after release.
REQ-037 The bench SHALL check streaming: out_ready=1 with in_data=0x10,0x14,0x18 on consecutive cycles -> the same values on out_data one cycle later each, occupancy constant at 1.
REQ-038 The bench SHALL check backpressure: out_ready=0 with 0xA0 then 0xA4 sent -> occupancy=2, in_ready=0, out_data held at 0xA0; out_ready=1 -> 0xA0 then 0xA4 in order.
REQ-039 The bench SHALL check flush: occupancy=2, then flush together with in_valid and in_data=0xFF -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xFF never emitted.
REQ-040 The bench SHALL check the bubble ctrl mask: in_ctrl=0xFF accepted then in_valid=0 -> out_ctrl=0xFF while valid, and 0x00 once drained.
REQ-041 The bench SHALL check mid-operation reset: rst with occupancy=2 -> occupancy=0 next cycle and no held entry emitted afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: occupancy states and
// default field widths used when the instantiator does not override them.
package pipe_pkg;

  // Number of entries currently held by the stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CTRL_W = 8;

  // Map a state to its held-entry count
  function automatic logic [1:0] occupancy_of(input state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the skid stage: a register with load enable.
// Clear wins over load so a reset or flush always empties the slot.
module pipe_slot #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture a new entry when loaded; clearing takes priority
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline register with a skid slot. The main slot always holds
// the oldest entry and drives the outputs; the skid slot catches the one
// instruction that arrives while downstream is stalled, which lets in_ready
// be a pure decode of registered state instead of depending on out_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int SLOT_W = CTRL_W + DATA_W;

  state_t            state;
  logic              accept;
  logic              pop;
  logic              slot_clear;
  logic              main_load;
  logic              skid_load;
  logic [SLOT_W-1:0] in_entry;
  logic [SLOT_W-1:0] main_d;
  logic [SLOT_W-1:0] main_q;
  logic [SLOT_W-1:0] skid_q;

  assign in_entry   = {in_ctrl, in_data};
  assign in_ready   = (state != TWO) & ~rst;
  assign out_valid  = (state != EMPTY);
  assign accept     = in_valid & in_ready & ~flush;
  assign pop        = out_valid & out_ready;
  assign slot_clear = rst | flush;

  assign out_data  = main_q[DATA_W-1:0];
  assign out_ctrl  = out_valid ? main_q[SLOT_W-1:DATA_W] : '0;
  assign occupancy = occupancy_of(state);

  // Decide which slot captures this cycle and where main's new value comes from
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_entry;
    case (state)
      EMPTY: begin
        main_load = accept;
      end
      ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end
      TWO: begin
        if (pop) begin
          main_load = 1'b1;
          main_d    = skid_q;
        end
      end
      default: begin
        main_load = 1'b0;
      end
    endcase
  end

  // Occupancy state machine; reset and flush both drop everything held
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !pop) begin
            state <= TWO;
          end else if (!accept && pop) begin
            state <= EMPTY;
          end
        end
        TWO: if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk   (clk),
    .clear (slot_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk   (clk),
    .clear (slot_clear),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

endmodule
